// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// PARITY_TX_EN (optional define) appends one even-parity bit to every frame.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } tx_state_t;

`ifdef PARITY_TX_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Frame length in bits for a given word width, including the optional parity bit.
  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/serial_pattern_tx_piso_shift.sv
// Parallel-load, left-shifting register; q_msb is the register's top bit.
// Used by serial_pattern_tx (PARITY_TX_EN does not affect this block).
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_msb
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= d;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign q_msb = sreg[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial transmitter: valid/ready word in, MSB-first bit stream out.
// Define PARITY_TX_EN to append an even-parity bit after the LSB of each frame.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_LEN - 1);
  localparam logic [3:0]    GAP_LOAD = 4'((GAP > 0) ? GAP - 1 : 0);

  tx_state_t     state, state_next;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    gap_cnt;
  logic          accept, shift_en, last_bit, gap_last;
  logic          q_msb, next_bit;

  assign last_bit = (bit_cnt == '0);
  assign gap_last = (gap_cnt == 4'd0);

  // The shifter is loaded one bit ahead, so q_msb always holds the bit due next cycle.
  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift_en),
    .d     ({load_data[WIDTH-2:0], 1'b0}),
    .q_msb (q_msb)
  );

`ifdef PARITY_TX_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^load_data;
    end
  end

  assign next_bit = (bit_cnt == CW'(1)) ? parity_q : q_msb;
`else
  assign next_bit = q_msb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    shift_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_valid) begin
          accept     = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          shift_en = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered copies of the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      gap_cnt    <= 4'd0;
      x_out      <= 1'b0;
      x_valid    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      load_ready <= (state_next == ST_IDLE);
      busy       <= (state_next != ST_IDLE);
      x_valid    <= (state_next == ST_SHIFT);
      done       <= (state == ST_SHIFT) && last_bit;
      if (accept) begin
        bit_cnt <= CNT_LOAD;
        x_out   <= load_data[WIDTH-1];
      end else if (shift_en) begin
        bit_cnt <= bit_cnt - CW'(1);
        x_out   <= next_bit;
      end else begin
        x_out <= 1'b0;
      end
      if ((state == ST_SHIFT) && last_bit) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == ST_GAP) && !gap_last) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx (GAP=1 and GAP=0 instances, WIDTH=8).
// Expected frames follow PARITY_TX_EN when the define is set for the build.
module tb_serial_pattern_tx;

`ifdef PARITY_TX_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int W      = 8;
  localparam int FLEN   = W + PAR;
  localparam int TB_GAP = 1;

  typedef logic bitq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ld_data = 8'h00, ld_data0 = 8'h00;
  logic       ld_valid = 1'b0, ld_valid0 = 1'b0;
  logic       load_ready, x_out, x_valid, busy, done;
  logic       load_ready0, x_out0, x_valid0, busy0, done0;
  int         n_checks = 0;
  int         n_fails  = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(W), .GAP(TB_GAP)) dut (
    .clk(clk), .rst(rst), .load_data(ld_data), .load_valid(ld_valid),
    .load_ready(load_ready), .x_out(x_out), .x_valid(x_valid), .busy(busy), .done(done)
  );

  serial_pattern_tx #(.WIDTH(W), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .load_data(ld_data0), .load_valid(ld_valid0),
    .load_ready(load_ready0), .x_out(x_out0), .x_valid(x_valid0), .busy(busy0), .done(done0)
  );

  // Observed outputs packed as {x_valid, x_out, done, busy, load_ready}.
  wire [4:0] obs  = {x_valid, x_out, done, busy, load_ready};
  wire [4:0] obs0 = {x_valid0, x_out0, done0, busy0, load_ready0};

  // Reference frame: word bits MSB first, then even parity when enabled.
  function automatic bitq_t model_frame(input logic [7:0] w);
    bitq_t q;
    for (int i = W - 1; i >= 0; i--) q.push_back(w[i]);
    if (PAR == 1) q.push_back(^w);
    return q;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== 5'b00001) begin
      n_fails++;
      $display("[TB] FAIL reset_gap1: got %b expected %b", obs, 5'b00001);
    end
    n_checks++;
    if (obs0 !== 5'b00001) begin
      n_fails++;
      $display("[TB] FAIL reset_gap0: got %b expected %b", obs0, 5'b00001);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== 5'b00001) begin
      n_fails++;
      $display("[TB] FAIL idle_after_reset: got %b expected %b", obs, 5'b00001);
    end
  endtask

  // One frame on the GAP=1 instance; pulse_at>=1 injects a stray load_valid mid-frame.
  task automatic run_frame(input logic [7:0] word, input int pulse_at, input string tag);
    bitq_t exp_bits;
    logic [4:0] exp;
    exp_bits = model_frame(word);
    @(negedge clk);
    n_checks++;
    if (obs !== 5'b00001) begin
      n_fails++;
      $display("[TB] FAIL %s_ready: got %b expected %b", tag, obs, 5'b00001);
    end
    ld_data  = word;
    ld_valid = 1'b1;
    for (int i = 0; i < FLEN; i++) begin
      @(negedge clk);
      ld_valid = 1'b0;
      if (i == pulse_at) begin
        ld_data  = 8'h00;
        ld_valid = 1'b1;
      end
      exp = {1'b1, exp_bits[i], 1'b0, 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("[TB] FAIL %s_bit%0d: got %b expected %b", tag, i, obs, exp);
      end
    end
    @(negedge clk);
    ld_valid = 1'b0;
    exp = {1'b0, 1'b0, 1'b1, (TB_GAP > 0), (TB_GAP == 0)};
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s_done: got %b expected %b", tag, obs, exp);
    end
    for (int g = 0; g < TB_GAP; g++) begin
      @(negedge clk);
      exp = {1'b0, 1'b0, 1'b0, (g < TB_GAP - 1), (g == TB_GAP - 1)};
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("[TB] FAIL %s_gap%0d: got %b expected %b", tag, g, obs, exp);
      end
    end
  endtask

  task automatic test_single_word();
    run_frame(8'hB4, -1, "word_b4");
    run_frame(8'h07, -1, "word_07");
  endtask

  task automatic test_ignore_busy();
    run_frame(8'hFF, 3, "ignore_busy");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== 5'b00001) begin
        n_fails++;
        $display("[TB] FAIL no_second_frame%0d: got %b expected %b", i, obs, 5'b00001);
      end
    end
  endtask

  task automatic test_random_words();
    logic [7:0] w;
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w = 8'($urandom);
      run_frame(w, -1, $sformatf("rand%0d_%02h", n, w));
    end
  endtask

  // Back-to-back on the GAP=0 instance with load_valid held high across frames.
  task automatic test_back_to_back(input int n_rand);
    logic [7:0] words[$];
    bitq_t      fr;
    logic [4:0] exp;
    int         k, p, n, total;
    words.push_back(8'h81);
    words.push_back(8'h7E);
    for (int i = 0; i < n_rand; i++) words.push_back(8'($urandom));
    n     = words.size();
    total = n * (FLEN + 1);
    @(negedge clk);
    n_checks++;
    if (obs0 !== 5'b00001) begin
      n_fails++;
      $display("[TB] FAIL b2b_ready: got %b expected %b", obs0, 5'b00001);
    end
    ld_data0  = words[0];
    ld_valid0 = 1'b1;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      k  = (c - 1) / (FLEN + 1);
      p  = (c - 1) % (FLEN + 1);
      fr = model_frame(words[k]);
      if (p < FLEN) exp = {1'b1, fr[p], 1'b0, 1'b1, 1'b0};
      else          exp = 5'b00101;
      n_checks++;
      if (obs0 !== exp) begin
        n_fails++;
        $display("[TB] FAIL b2b_w%0d_c%0d: got %b expected %b", k, p, obs0, exp);
      end
      if (p == FLEN && k + 1 < n) ld_data0 = words[k + 1];
      if (p == 0 && k == n - 1) ld_valid0 = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== 5'b00001) begin
        n_fails++;
        $display("[TB] FAIL b2b_idle%0d: got %b expected %b", i, obs0, 5'b00001);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bitq_t exp_bits;
    logic [4:0] exp;
    exp_bits = model_frame(8'hAA);
    @(negedge clk);
    ld_data  = 8'hAA;
    ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ld_valid = 1'b0;
      exp = {1'b1, exp_bits[i], 1'b0, 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("[TB] FAIL midrst_bit%0d: got %b expected %b", i, obs, exp);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== 5'b00001) begin
      n_fails++;
      $display("[TB] FAIL midrst_cut: got %b expected %b", obs, 5'b00001);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== 5'b00001) begin
        n_fails++;
        $display("[TB] FAIL midrst_quiet%0d: got %b expected %b", i, obs, 5'b00001);
      end
    end
    run_frame(8'h5C, -1, "after_midrst");
  endtask

  initial begin
    $display("[TB] serial_pattern_tx bench start, frame length %0d", FLEN);
    test_reset();
    test_single_word();
    test_ignore_busy();
    test_back_to_back(4);
    test_random_words();
    test_reset_mid_frame();
    test_back_to_back(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
